// File: rtl/div_seq.sv
// div_seq: iterative 32-bit restoring divider for the execute stage.
// One quotient bit per clock over 32 iterations, plus a finalize edge that
// applies the sign fix-ups. Divide-by-zero short-circuits to the RISC-V
// result {dividend, all-ones}. The result and ready flag are held until the
// requester drops start_i, and annul_i aborts from any state.

module div_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  typedef enum logic [1:0] {
    FREE   = 2'b00,
    BYZERO = 2'b01,
    ON     = 2'b10,
    END    = 2'b11
  } divState_e;

  divState_e   state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [32:0] r_q, r_d;
  logic [31:0] q_q, q_d;
  logic [31:0] d_q, d_d;
  logic        negQ_q, negQ_d;
  logic        negR_q, negR_d;
  logic [63:0] result_q, result_d;
  logic        ready_q, ready_d;

  logic        sign1;
  logic        sign2;
  logic [31:0] mag1;
  logic [31:0] mag2;
  logic [33:0] stepT;
  logic [33:0] stepDiff;
  logic        stepGe;
  logic [31:0] finalQuot;
  logic [31:0] finalRem;

  // Operand magnitudes and sign flags taken when a request is accepted.
  always_comb begin
    sign1 = signed_div_i & opdata1_i[31];
    sign2 = signed_div_i & opdata2_i[31];
    mag1  = sign1 ? (32'd0 - opdata1_i) : opdata1_i;
    mag2  = sign2 ? (32'd0 - opdata2_i) : opdata2_i;
  end

  // One restoring step: shift the next dividend bit into the partial
  // remainder and subtract the divisor when it fits. The partial remainder
  // is always below the divisor, so its top bit stays zero.
  always_comb begin
    stepT    = {r_q, q_q[31]};
    stepGe   = (stepT >= {2'b00, d_q});
    stepDiff = stepT - {2'b00, d_q};
  end

  // Sign correction of the finished magnitudes.
  always_comb begin
    finalQuot = negQ_q ? (32'd0 - q_q) : q_q;
    finalRem  = negR_q ? (32'd0 - r_q[31:0]) : r_q[31:0];
  end

  // Next-state and datapath control; annul_i overrides everything.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    r_d      = r_q;
    q_d      = q_q;
    d_d      = d_q;
    negQ_d   = negQ_q;
    negR_d   = negR_q;
    result_d = result_q;
    ready_d  = ready_q;

    unique case (state_q)
      FREE: begin
        if (start_i && !annul_i) begin
          if (opdata2_i == 32'd0) begin
            state_d = BYZERO;
          end else begin
            state_d = ON;
            cnt_d   = 6'd0;
            r_d     = 33'd0;
            q_d     = mag1;
            d_d     = mag2;
            negQ_d  = sign1 ^ sign2;
            negR_d  = sign1;
          end
        end
      end

      BYZERO: begin
        if (annul_i) begin
          state_d  = FREE;
          result_d = 64'd0;
          ready_d  = 1'b0;
        end else begin
          state_d  = END;
          result_d = {opdata1_i, 32'hFFFF_FFFF};
          ready_d  = 1'b1;
        end
      end

      ON: begin
        if (annul_i) begin
          state_d  = FREE;
          result_d = 64'd0;
          ready_d  = 1'b0;
        end else if (cnt_q != 6'd32) begin
          if (stepGe) begin
            r_d = stepDiff[32:0];
            q_d = {q_q[30:0], 1'b1};
          end else begin
            r_d = stepT[32:0];
            q_d = {q_q[30:0], 1'b0};
          end
          cnt_d = cnt_q + 6'd1;
        end else begin
          state_d  = END;
          result_d = {finalRem, finalQuot};
          ready_d  = 1'b1;
        end
      end

      END: begin
        if (annul_i || !start_i) begin
          state_d  = FREE;
          result_d = 64'd0;
          ready_d  = 1'b0;
        end
      end

      default: begin
        state_d  = FREE;
        result_d = 64'd0;
        ready_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= FREE;
      cnt_q    <= 6'd0;
      r_q      <= 33'd0;
      q_q      <= 32'd0;
      d_q      <= 32'd0;
      negQ_q   <= 1'b0;
      negR_q   <= 1'b0;
      result_q <= 64'd0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      r_q      <= r_d;
      q_q      <= q_d;
      d_q      <= d_d;
      negQ_q   <= negQ_d;
      negR_q   <= negR_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: table-driven and randomized checks of div_seq against a plain
// arithmetic reference, plus hand-written annul and reset sequences.

module tb_div_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    bit          sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[9];

  div_seq dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Reference: plain integer division with truncation toward zero, remainder
  // taking the dividend's sign; divide-by-zero gives {dividend, all-ones}.
  function automatic logic [63:0] refDivide(input bit sgn, input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa;
    longint sb;
    longint qq;
    longint rr;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'(a);
      sb = longint'(b);
    end
    qq = sa / sb;
    rr = sa % sb;
    return {rr[31:0], qq[31:0]};
  endfunction

  // Issue a request and count clock edges (E0 = 1) until ready_o is seen.
  task automatic applyStimulus(input bit sgn, input logic [31:0] a,
                               input logic [31:0] b,
                               output logic [63:0] res, output int edges);
    @(negedge clk);
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    @(posedge clk);
    edges = 1;
    #1;
    if (b != 32'd0) begin
      opdata1_i = $urandom;
      opdata2_i = $urandom | 32'd1;
    end
    while (!ready_o && edges < 60) begin
      @(posedge clk);
      edges++;
      #1;
    end
    res = result_o;
  endtask

  // Full transaction: result, latency, hold while start stays high, release.
  task automatic runVector(input string name, input bit sgn, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] exp,
                           input bit checkHold);
    logic [63:0] res;
    int          edges;
    applyStimulus(sgn, a, b, res, edges);
    checkOutput({name, " result"}, res, exp);
    checkOutput({name, " latency"}, 64'(edges), (b == 32'd0) ? 64'd2 : 64'd34);
    if (checkHold) begin
      repeat (2) begin
        @(posedge clk);
        #1;
      end
      checkOutput({name, " hold ready"}, 64'(ready_o), 64'd1);
      checkOutput({name, " hold result"}, result_o, exp);
    end
    @(negedge clk);
    start_i = 1'b0;
    @(posedge clk);
    #1;
    checkOutput({name, " drop ready"}, 64'(ready_o), 64'd0);
    checkOutput({name, " drop result"}, result_o, 64'd0);
  endtask

  initial begin
    logic [63:0] res;
    int          edges;
    int          readySeen;
    bit          sgn;
    logic [31:0] a;
    logic [31:0] b;

    vecs[0] = '{"u100/7",      1'b0, 32'd100,        32'd7,          {32'd2, 32'd14}};
    vecs[1] = '{"s-7/2",       1'b1, 32'hFFFF_FFF9,  32'd2,          {32'hFFFF_FFFF, 32'hFFFF_FFFD}};
    vecs[2] = '{"u-7/2",       1'b0, 32'hFFFF_FFF9,  32'd2,          {32'h1, 32'h7FFF_FFFC}};
    vecs[3] = '{"s1234/0",     1'b1, 32'h1234,       32'd0,          {32'h1234, 32'hFFFF_FFFF}};
    vecs[4] = '{"u1234/0",     1'b0, 32'h1234,       32'd0,          {32'h1234, 32'hFFFF_FFFF}};
    vecs[5] = '{"sovf",        1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  {32'h0, 32'h8000_0000}};
    vecs[6] = '{"umax/1",      1'b0, 32'hFFFF_FFFF,  32'd1,          {32'h0, 32'hFFFF_FFFF}};
    vecs[7] = '{"s7/-2",       1'b1, 32'd7,          32'hFFFF_FFFE,  {32'h1, 32'hFFFF_FFFD}};
    vecs[8] = '{"u5/9",        1'b0, 32'd5,          32'd9,          {32'd5, 32'd0}};

    rst          = 1'b0;
    signed_div_i = 1'b0;
    opdata1_i    = 32'd0;
    opdata2_i    = 32'd0;
    start_i      = 1'b0;
    annul_i      = 1'b0;
    #1;
    checkOutput("reset ready", 64'(ready_o), 64'd0);
    checkOutput("reset result", result_o, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 9; i++) begin
      runVector(vecs[i].name, vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].exp, i < 4);
    end

    for (int i = 0; i < 40; i++) begin
      sgn = 1'($urandom_range(0, 1));
      a   = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : 32'($urandom);
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = 32'($urandom_range(1, 16));
        default: b = 32'($urandom);
      endcase
      runVector($sformatf("rand%0d", i), sgn, a, b, refDivide(sgn, a, b), 1'b0);
    end

    // Annul in the middle of an iteration: no result may ever appear.
    @(negedge clk);
    signed_div_i = 1'b0;
    opdata1_i    = 32'd100;
    opdata2_i    = 32'd7;
    start_i      = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    annul_i = 1'b1;
    start_i = 1'b0;
    @(posedge clk);
    #1;
    annul_i = 1'b0;
    readySeen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (ready_o || result_o != 64'd0) readySeen++;
    end
    checkOutput("annul no ready", 64'(readySeen), 64'd0);
    runVector("post-annul 20/3", 1'b0, 32'd20, 32'd3, {32'd2, 32'd6}, 1'b0);

    // Asynchronous reset in the middle of the iteration.
    @(negedge clk);
    signed_div_i = 1'b0;
    opdata1_i    = 32'd100;
    opdata2_i    = 32'd7;
    start_i      = 1'b1;
    repeat (16) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("midop reset ready", 64'(ready_o), 64'd0);
    checkOutput("midop reset result", result_o, 64'd0);
    start_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    readySeen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (ready_o) readySeen++;
    end
    checkOutput("midop abort", 64'(readySeen), 64'd0);

    // Asynchronous reset while a finished result is being held.
    applyStimulus(1'b0, 32'd100, 32'd7, res, edges);
    checkOutput("held before reset", res, {32'd2, 32'd14});
    #2;
    rst = 1'b0;
    #1;
    checkOutput("held reset ready", 64'(ready_o), 64'd0);
    checkOutput("held reset result", result_o, 64'd0);
    start_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    runVector("post-reset 9/3", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
